// File: rtl/prod_bin2bcd_seq_if.sv
// Handshake bundle between the product source and the BCD converter.
// The master drives load/bin_in and observes the converter's result; the
// slave is the converter itself.
interface prod_bin2bcd_seq_if #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
);
    logic                  load;
    logic [WIDTH-1:0]      bin_in;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;

    modport master (
        output load,
        output bin_in,
        input  bcd,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  bin_in,
        output bcd,
        output busy,
        output done
    );
endinterface

// File: rtl/prod_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// One input bit is consumed per clock; a conversion takes WIDTH edges from
// the accepted load to done. A load is accepted in IDLE or DONE only, so
// back-to-back conversions can restart on the done cycle.
// Optional build macro BCD_LEADING_ZERO_BLANK_EN: replaces leading zero
// digits (never digit 0) with 4'hF in the registered result.
module prod_bin2bcd_seq #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    prod_bin2bcd_seq_if.slave    bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t                state;
    logic [WIDTH-1:0]      shreg;
    logic [4*DIGITS-1:0]   acc;
    logic [CW-1:0]         cnt;
    logic [4*DIGITS-1:0]   nxt_acc;
    logic [4*DIGITS-1:0]   final_bcd;

    // Next accumulator: add 3 to every digit >= 5, then shift in the next input bit
    always_comb begin
        nxt_acc = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (nxt_acc[4*i +: 4] >= 4'd5) begin
                nxt_acc[4*i +: 4] = nxt_acc[4*i +: 4] + 4'd3;
            end
        end
        nxt_acc    = nxt_acc << 1;
        nxt_acc[0] = shreg[WIDTH-1];
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic leading;

    // Blank leading zero digits from the top down, always keeping the units digit
    always_comb begin
        final_bcd = nxt_acc;
        leading   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && (nxt_acc[4*i +: 4] == 4'd0)) begin
                final_bcd[4*i +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    // Without blanking the completed accumulator is the result as-is
    always_comb begin
        final_bcd = nxt_acc;
    end
`endif

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            bus.bcd  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.load) begin
                        shreg    <= bus.bin_in;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= CONV;
                        bus.busy <= 1'b1;
                        bus.done <= 1'b0;
                    end
                end
                CONV: begin
                    acc   <= nxt_acc;
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.bcd  <= final_bcd;
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prod_bin2bcd_seq.sv
// Self-checking bench for prod_bin2bcd_seq: directed boundary cases plus
// randomized conversions compared against a decimal-arithmetic model.
module tb_prod_bin2bcd_seq;

    localparam int WIDTH  = 12;
    localparam int DIGITS = 4;

    logic clk;
    logic rst;
    int   numChecks;
    int   numFailures;
    logic [15:0] expBcd;

    prod_bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    prod_bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: digits taken by division, optional leading-zero blanking
    function automatic logic [15:0] bcdModel(input int value);
        logic [15:0] res;
        int          pow;
        bit          leading;
        res = '0;
        pow = 1;
        for (int d = 0; d < DIGITS; d++) begin
            res[4*d +: 4] = 4'((value / pow) % 10);
            pow = pow * 10;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        leading = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (leading && res[4*d +: 4] == 4'd0) res[4*d +: 4] = 4'hF;
            else leading = 1'b0;
        end
`else
        leading = 1'b0;
`endif
        return res;
    endfunction

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFailures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Run one conversion from IDLE/DONE, optionally injecting a load or reset
    // mid-conversion, then watch the held result for holdCycles idle edges
    task automatic applyStimulus(input int value, input int glitchCycle,
                                 input bit glitchReset, input int glitchValue,
                                 input int holdCycles);
        int edges;
        bit aborted;
        bit rstApplied;
        edges      = 0;
        aborted    = 1'b0;
        rstApplied = 1'b0;
        bus.bin_in = 12'(value);
        bus.load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.load   = 1'b0;
        bus.bin_in = 12'($urandom_range(0, 4095));
        checkOutput("loadBusy", 32'(bus.busy), 32'd1);
        checkOutput("loadDone", 32'(bus.done), 32'd0);
        checkOutput("loadHoldBcd", 32'(bus.bcd), 32'(expBcd));
        while (!bus.done && edges < 40 && !aborted) begin
            if (edges == glitchCycle) begin
                if (glitchReset) begin
                    rst        = 1'b1;
                    rstApplied = 1'b1;
                end else begin
                    bus.load   = 1'b1;
                    bus.bin_in = 12'(glitchValue);
                end
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == glitchCycle + 1) begin
                rst      = 1'b0;
                bus.load = 1'b0;
            end
            if (rstApplied) begin
                expBcd  = '0;
                aborted = 1'b1;
                checkOutput("abortBcd", 32'(bus.bcd), 32'd0);
                checkOutput("abortBusy", 32'(bus.busy), 32'd0);
                checkOutput("abortDone", 32'(bus.done), 32'd0);
            end else begin
                checkOutput("busyDoneExcl", 32'(bus.busy & bus.done), 32'd0);
            end
        end
        if (!aborted) begin
            expBcd = bcdModel(value);
            checkOutput("latency", 32'(edges), 32'(WIDTH));
            checkOutput("doneFlag", 32'(bus.done), 32'd1);
            checkOutput("busyFlag", 32'(bus.busy), 32'd0);
            checkOutput("result", 32'(bus.bcd), 32'(expBcd));
            for (int h = 0; h < holdCycles; h++) begin
                bus.bin_in = 12'($urandom_range(0, 4095));
                @(posedge clk);
                @(negedge clk);
                checkOutput("holdBcd", 32'(bus.bcd), 32'(expBcd));
                checkOutput("holdDone", 32'(bus.done), 32'd1);
            end
        end
    endtask

    // Main sequence: reset, directed cases, then randomized conversions
    initial begin
        int value;
        int gc;
        numChecks   = 0;
        numFailures = 0;
        expBcd      = '0;
        rst         = 1'b1;
        bus.load    = 1'b0;
        bus.bin_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetBcd", 32'(bus.bcd), 32'd0);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetDone", 32'(bus.done), 32'd0);

        applyStimulus(1824, -1, 1'b0, 0, 3);
        applyStimulus(0,    -1, 1'b0, 0, 1);
        applyStimulus(4095, -1, 1'b0, 0, 1);
        applyStimulus(9,    -1, 1'b0, 0, 1);
        applyStimulus(7,    -1, 1'b0, 0, 0);
        applyStimulus(305,  -1, 1'b0, 0, 0);
        applyStimulus(1024, -1, 1'b0, 0, 1);

        applyStimulus(1000, 5, 1'b0, 555, 0);
        applyStimulus(555,  -1, 1'b0, 0, 2);

        applyStimulus(4095, 6, 1'b1, 0, 0);
        applyStimulus(37,   -1, 1'b0, 0, 1);

        for (int n = 0; n < 24; n++) begin
            value = int'($urandom_range(0, 4095));
            gc    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            applyStimulus(value, gc, 1'b0, int'($urandom_range(0, 4095)),
                          int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
        $finish;
    end

endmodule
